ldstr_arb_ctrl: RTL

Sequencer and arbiter for the shared load/store memory port of the 3-stage pipeline. It grants either the instruction-fetch requester or the load/store (data) requester. It loads the winner's address and write data into its internal n-bit load/store registers, then runs a req/ack handshake with memory. Read data is captured into the data register and a one-cycle done pulse returns it, with stall-level busy status to the pipeline.

---
 rtl/ldstr_arb_ctrl_if.sv | 49 ++++
 rtl/ldstr_arb_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ldstr_arb_ctrl_if.sv
// rtl/ldstr_arb_ctrl_if.sv - pipeline and memory-side bundle of the shared load/store port
//
// Purpose: groups the fetch requester, the data requester and the memory
// port of ldstr_arb_ctrl into one bundle.
//   slave  modport : the controller side (ldstr_arb_ctrl)
//   master modport : the pipeline / memory side driving requests and acks
// Signals:
//   if_req, if_addr, if_done             fetch requester
//   ls_req, ls_we, ls_addr, ls_wdata,    data requester
//   ls_done
//   rdata, err, busy                     shared status back to the pipeline
//   mem_req, mem_we, mem_addr,           memory request side
//   mem_wdata
//   mem_ack, mem_rdata                   memory response side
interface ldstr_arb_ctrl_if #(
    parameter int n = 32
);
    logic         if_req;
    logic [n-1:0] if_addr;
    logic         if_done;
    logic         ls_req;
    logic         ls_we;
    logic [n-1:0] ls_addr;
    logic [n-1:0] ls_wdata;
    logic         ls_done;
    logic [n-1:0] rdata;
    logic         err;
    logic         busy;
    logic         mem_req;
    logic         mem_we;
    logic [n-1:0] mem_addr;
    logic [n-1:0] mem_wdata;
    logic         mem_ack;
    logic [n-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
               mem_ack, mem_rdata,
        output if_done, ls_done, rdata, err, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
               mem_ack, mem_rdata,
        input  if_done, ls_done, rdata, err, busy,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ldstr_arb_ctrl.sv
// rtl/ldstr_arb_ctrl.sv - fetch/data arbiter and req/ack sequencer for the shared memory port
//
// Purpose: grants the fetch or the data requester (round-robin on a tie),
// loads the winner's address/store data into the address and data
// registers, runs a level req/ack handshake with memory bounded by a
// timeout counter, and returns a one-cycle done (plus err on timeout).
// Ports:
//   clk   rising-edge clock
//   clr   asynchronous active-high reset
//   bus   ldstr_arb_ctrl_if.slave: requesters, status and memory port
module ldstr_arb_ctrl #(
    parameter int n  = 32,
    parameter int TW = 4
) (
    input  logic             clk,
    input  logic             clr,
    ldstr_arb_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TW-1:0] LIMIT = {TW{1'b1}};

    // Owner / last-grant encoding: 0 = fetch, 1 = data.
    state_t        state_q,    state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          owner_q,    owner_d;
    logic          we_q,       we_d;
    logic          err_q,      err_d;
    logic [TW-1:0] cnt_q,      cnt_d;
    logic [n-1:0]  addr_q,     addr_d;
    logic [n-1:0]  data_q,     data_d;

    logic gnt_ls;
    logic gnt_if;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Data wins a tie unless it was the last one served.
    assign gnt_ls = bus.ls_req & (~bus.if_req | ~last_gnt_q);
    assign gnt_if = bus.if_req & ~gnt_ls;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_ls || gnt_if) begin
                    addr_d     = gnt_ls ? bus.ls_addr : bus.if_addr;
                    // Only a store preloads the data register; loads and
                    // fetches overwrite it from mem_rdata on ack.
                    if (gnt_ls && bus.ls_we) begin
                        data_d = bus.ls_wdata;
                    end
                    we_d       = gnt_ls & bus.ls_we;
                    owner_d    = gnt_ls;
                    last_gnt_d = gnt_ls;
                    cnt_d      = '0;
                    state_d    = MEM;
                end
            end
            MEM: begin
                // Ack has priority over the timeout limit in the same cycle.
                if (bus.mem_ack) begin
                    if (!we_q) begin
                        data_d = bus.mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == LIMIT - TW'(1)) begin
                    // This idle cycle brings the count to the limit.
                    cnt_d   = LIMIT;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state, so clr drops them immediately.
    assign bus.mem_req   = (state_q == MEM);
    assign bus.mem_we    = (state_q == MEM) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;
    assign bus.rdata     = data_q;
    assign bus.busy      = (state_q == MEM) | (state_q == DONE);
    assign bus.if_done   = (state_q == DONE) & ~owner_q;
    assign bus.ls_done   = (state_q == DONE) & owner_q;
    assign bus.err       = (state_q == DONE) & err_q;

endmodule
